// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the program counter, requests one instruction
// word per fetch, holds it for the control unit until STEP, then computes the
// next PC (hold / +4 / branch / register jump). A misaligned PC or a memory
// that does not answer within TIMEOUT cycles parks the unit in a sticky fault.
module inst_fetch #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [1:0]  PC_SEL,
    input  logic        PC_MUX,
    input  logic [63:0] K,
    input  logic [63:0] A,
    input  logic        STEP,
    output logic        MEM_RD,
    output logic [63:0] MEM_ADDR,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ACK,
    output logic [31:0] Inst,
    output logic        INST_VALID,
    output logic [63:0] PC,
    output logic        FAULT
);

    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_UPDATE, S_FAULT} state_t;

    state_t        state_q;
    logic [63:0]   pc_q, pc_d;
    logic [31:0]   inst_q;
    logic          rd_q, vld_q, fault_q;
    logic [WW-1:0] wait_q;
    logic [63:0]   br_off;

    // Only the low 26 bits of K carry the word offset.
    logic unused_k;
    assign unused_k = ^K[63:26];

    // Word offset -> byte offset, sign-extended to the full PC width.
    assign br_off = {{36{K[25]}}, K[25:0], 2'b00};

    // Next-PC selection; arithmetic wraps silently at 2^64.
    always_comb begin
        pc_d = pc_q;
        case (PC_SEL)
            2'b01:   pc_d = pc_q + 64'd4;
            2'b10:   pc_d = PC_MUX ? (pc_q + br_off) : A;
            2'b11:   pc_d = A;
            default: pc_d = pc_q;
        endcase
    end

    // Fetch/hold/update/fault sequencer with registered outputs.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_FETCH;
            pc_q    <= 64'd0;
            inst_q  <= 32'd0;
            rd_q    <= 1'b0;
            vld_q   <= 1'b0;
            fault_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (!rd_q) begin
                        // First cycle out of reset: issue the request; any ack
                        // seen before the request is up is stale and dropped.
                        rd_q   <= 1'b1;
                        wait_q <= '0;
                    end else if (MEM_ACK) begin
                        inst_q  <= MEM_RDATA;
                        rd_q    <= 1'b0;
                        vld_q   <= 1'b1;
                        wait_q  <= '0;
                        state_q <= S_HOLD;
                    end else if (wait_q == WAIT_LAST) begin
                        rd_q    <= 1'b0;
                        fault_q <= 1'b1;
                        state_q <= S_FAULT;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    // PC_SEL=00 keeps the current instruction (multicycle ops).
                    if (STEP && (PC_SEL != 2'b00)) begin
                        pc_q    <= pc_d;
                        vld_q   <= 1'b0;
                        state_q <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (pc_q[1:0] != 2'b00) begin
                        fault_q <= 1'b1;
                        state_q <= S_FAULT;
                    end else begin
                        rd_q    <= 1'b1;
                        wait_q  <= '0;
                        state_q <= S_FETCH;
                    end
                end
                S_FAULT: begin
                    // Sticky until Reset; everything frozen.
                    rd_q  <= 1'b0;
                    vld_q <= 1'b0;
                end
                default: state_q <= S_FAULT;
            endcase
        end
    end

    assign MEM_RD     = rd_q;
    assign MEM_ADDR   = pc_q;
    assign PC         = pc_q;
    assign Inst       = inst_q;
    assign INST_VALID = vld_q;
    assign FAULT      = fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a behavioural instruction memory with programmable
// wait states, a scoreboard of expected {PC, Inst} pairs pushed whenever a
// step is issued and popped when INST_VALID rises, plus direct latency/fault checks.
module tb_inst_fetch;

    logic        CLK, Reset;
    logic [1:0]  PC_SEL;
    logic        PC_MUX;
    logic [63:0] K, A;
    logic        STEP;
    logic        MEM_RD;
    logic [63:0] MEM_ADDR;
    logic [31:0] MEM_RDATA;
    logic        MEM_ACK;
    logic [31:0] Inst;
    logic        INST_VALID;
    logic [63:0] PC;
    logic        FAULT;

    inst_fetch #(.TIMEOUT(16)) dut (
        .CLK(CLK), .Reset(Reset), .PC_SEL(PC_SEL), .PC_MUX(PC_MUX), .K(K), .A(A),
        .STEP(STEP), .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
        .MEM_ACK(MEM_ACK), .Inst(Inst), .INST_VALID(INST_VALID), .PC(PC), .FAULT(FAULT)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          ack_delay = 0;
    logic        force_ack = 1'b0;
    int          rd_cnt = 0;
    logic [63:0] tb_pc = 64'd0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] memf(input logic [63:0] a);
        if (a == 64'd0) return 32'h8B020020;
        return a[31:0] ^ {a[63:48], 16'hC3A5};
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Instruction memory: answers ack_delay cycles into a request.
    initial begin
        int wcnt;
        wcnt = 0;
        MEM_ACK = 1'b0;
        MEM_RDATA = 32'd0;
        forever begin
            @(negedge CLK);
            if (force_ack) begin
                MEM_ACK = 1'b1;
                MEM_RDATA = 32'hDEADBEEF;
                wcnt = 0;
            end else if (MEM_RD) begin
                if (wcnt >= ack_delay) begin
                    MEM_ACK = 1'b1;
                    MEM_RDATA = memf(MEM_ADDR);
                    wcnt = 0;
                end else begin
                    MEM_ACK = 1'b0;
                    MEM_RDATA = 32'd0;
                    wcnt++;
                end
            end else begin
                MEM_ACK = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Scoreboard monitor: each rising INST_VALID consumes one expectation.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (INST_VALID && !prev) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_pc", PC, e.pc);
                    chk("sb_addr", MEM_ADDR, e.pc);
                    chk("sb_inst", {32'd0, Inst}, {32'd0, e.inst});
                end
            end
            prev = INST_VALID;
            if (MEM_RD) rd_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // Reset for one edge (optionally with STEP/forced ack in the same cycle),
    // check the reset state, then return on the release edge.
    task automatic do_reset(input logic with_step, input logic fa);
        @(posedge CLK); #1;
        Reset = 1'b1;
        STEP = with_step;
        PC_SEL = 2'b01;
        force_ack = fa;
        @(posedge CLK); #1;
        STEP = 1'b0;
        force_ack = 1'b0;
        chk("rst_pc", PC, 64'd0);
        chk("rst_inst", {32'd0, Inst}, 64'd0);
        chk("rst_vld", {63'd0, INST_VALID}, 64'd0);
        chk("rst_rd", {63'd0, MEM_RD}, 64'd0);
        chk("rst_fault", {63'd0, FAULT}, 64'd0);
        sb_q.delete();
        tb_pc = 64'd0;
        sb_q.push_back('{pc: 64'd0, inst: memf(64'd0)});
        Reset = 1'b0;
        @(posedge CLK);
    endtask

    // Count negedges until INST_VALID; bounded.
    task automatic wait_valid(input int exp_n, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!INST_VALID && n < 60);
        chk(tag, n, exp_n);
    endtask

    // Issue one STEP; the reference next-PC is computed here from the command.
    task automatic step(input logic [1:0] sel, input logic mux, input logic [63:0] k,
                        input logic [63:0] a, input logic ok);
        logic [63:0] np;
        case (sel)
            2'b01:   np = tb_pc + 64'd4;
            2'b10:   np = mux ? tb_pc + {{36{k[25]}}, k[25:0], 2'b00} : a;
            2'b11:   np = a;
            default: np = tb_pc;
        endcase
        @(posedge CLK); #1;
        PC_SEL = sel; PC_MUX = mux; K = k; A = a; STEP = 1'b1;
        @(posedge CLK); #1;
        STEP = 1'b0;
        tb_pc = np;
        if (sel != 2'b00 && ok) sb_q.push_back('{pc: np, inst: memf(np)});
    endtask

    initial begin
        int r0, n;
        logic [31:0] inst0;
        logic [63:0] pc0;
        Reset = 1'b1; STEP = 1'b0; PC_SEL = 2'b00; PC_MUX = 1'b0; K = 64'd0; A = 64'd0;
        repeat (2) @(posedge CLK);

        // Reset and first fetch from address 0.
        do_reset(1'b0, 1'b0);
        wait_valid(2, "rst_lat");

        // Increment, relative branch (backwards, junk in K[63:26]), A-bus branch, jump.
        step(2'b11, 1'b0, 64'd0, 64'h100, 1'b1);          wait_valid(3, "jmp_lat");
        step(2'b01, 1'b0, 64'd0, 64'd0, 1'b1);            wait_valid(3, "inc_lat");
        step(2'b11, 1'b0, 64'd0, 64'h100, 1'b1);          wait_valid(3, "jmp2_lat");
        step(2'b10, 1'b1, 64'hABCD_0000_03FF_FFFE, 64'h5555, 1'b1); wait_valid(3, "brk_lat");
        chk("brk_pc", PC, 64'hF8);
        step(2'b10, 1'b0, 64'h40, 64'h3000, 1'b1);        wait_valid(3, "bra_lat");
        step(2'b11, 1'b1, 64'h40, 64'h2000, 1'b1);        wait_valid(3, "jmpm_lat");
        step(2'b10, 1'b1, 64'h10, 64'd0, 1'b1);           wait_valid(3, "brf_lat");

        // PC_SEL=00 three times: no refetch, everything held.
        r0 = rd_cnt; inst0 = Inst; pc0 = PC;
        repeat (3) step(2'b00, 1'b0, 64'd0, 64'd0, 1'b1);
        repeat (4) @(negedge CLK);
        chk("hold_rd", rd_cnt, r0);
        chk("hold_inst", {32'd0, Inst}, {32'd0, inst0});
        chk("hold_pc", PC, pc0);
        chk("hold_vld", {63'd0, INST_VALID}, 64'd1);

        // Stray ack while holding must not disturb Inst.
        @(posedge CLK); #1; force_ack = 1'b1;
        repeat (3) @(negedge CLK);
        #1; force_ack = 1'b0;
        @(negedge CLK);
        chk("stray_inst", {32'd0, Inst}, {32'd0, inst0});
        chk("stray_vld", {63'd0, INST_VALID}, 64'd1);

        // Ack on the last allowed wait cycle completes; shorter wait too.
        ack_delay = 15;
        step(2'b01, 1'b0, 64'd0, 64'd0, 1'b1); wait_valid(18, "ack_last_lat");
        chk("ack_last_fault", {63'd0, FAULT}, 64'd0);
        ack_delay = 3;
        step(2'b01, 1'b0, 64'd0, 64'd0, 1'b1); wait_valid(6, "ack3_lat");
        ack_delay = 0;

        // Reset wins over a simultaneous STEP.
        do_reset(1'b1, 1'b0);
        wait_valid(2, "rst_step_lat");

        // Wrap-around at the top of the address space.
        step(2'b11, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1); wait_valid(3, "top_lat");
        step(2'b01, 1'b0, 64'd0, 64'd0, 1'b1);                   wait_valid(3, "wrap_lat");
        chk("wrap_pc", PC, 64'd0);
        chk("wrap_fault", {63'd0, FAULT}, 64'd0);

        // Misaligned jump faults after UPDATE; STEP in fault ignored.
        step(2'b11, 1'b0, 64'd0, 64'h2002, 1'b1);
        @(negedge CLK);
        chk("mis_upd_fault", {63'd0, FAULT}, 64'd0);
        @(negedge CLK);
        chk("mis_fault", {63'd0, FAULT}, 64'd1);
        chk("mis_rd", {63'd0, MEM_RD}, 64'd0);
        chk("mis_vld", {63'd0, INST_VALID}, 64'd0);
        chk("mis_pc", PC, 64'h2002);
        r0 = rd_cnt;
        @(posedge CLK); #1; PC_SEL = 2'b01; STEP = 1'b1;
        @(posedge CLK); #1; STEP = 1'b0;
        repeat (5) @(negedge CLK);
        chk("mis_sticky", {63'd0, FAULT}, 64'd1);
        chk("mis_frozen", PC, 64'h2002);
        chk("mis_no_rd", rd_cnt, r0);
        do_reset(1'b0, 1'b0);
        wait_valid(2, "mis_rst_lat");

        // Memory never answers: fault after 16 waiting fetch cycles.
        ack_delay = 1000;
        step(2'b01, 1'b0, 64'd0, 64'd0, 1'b0);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!FAULT && n < 60);
        chk("to_lat", n, 18);
        chk("to_rd", {63'd0, MEM_RD}, 64'd0);
        chk("to_vld", {63'd0, INST_VALID}, 64'd0);
        repeat (4) @(negedge CLK);
        chk("to_sticky", {63'd0, FAULT}, 64'd1);
        chk("to_pc", PC, 64'd4);

        // Reset in the middle of a 5-cycle wait; ack during Reset is discarded.
        ack_delay = 0;
        do_reset(1'b0, 1'b0);
        wait_valid(2, "to_rst_lat");
        ack_delay = 5;
        step(2'b01, 1'b0, 64'd0, 64'd0, 1'b0);
        repeat (4) @(negedge CLK);
        do_reset(1'b0, 1'b1);
        wait_valid(7, "midrst_lat");
        chk("midrst_fault", {63'd0, FAULT}, 64'd0);

        repeat (3) @(negedge CLK);
        chk("sb_drained", sb_q.size(), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have port: CLK  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: Reset  input  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-003 SHALL have port: PC_SEL  input  2  next-PC command from control unit: 00 hold, 01 increment, 10 branch, 11 register jump.
REQ-004 SHALL have port: PC_MUX  input  1  branch-target source: 1 = PC-relative via K, 0 = A bus.
REQ-005 SHALL have port: K  input  64  branch word offset; bits [25:0] used, signed.
REQ-006 SHALL have port: A  input  64  register-file A bus, absolute target.
REQ-007 SHALL have port: STEP  input  1  one-cycle strobe: PC_SEL/PC_MUX/K/A valid this cycle.
REQ-008 SHALL have port: MEM_RD  output  1  instruction-memory read request.
REQ-009 SHALL have port: MEM_ADDR  output  64  read address; always equals PC.
REQ-010 SHALL have port: MEM_RDATA  input  32  instruction word returned by memory.
REQ-011 SHALL have port: MEM_ACK  input  1  MEM_RDATA valid this cycle.
REQ-012 SHALL have port: Inst  output  32  current instruction to control unit.
REQ-013 SHALL have port: INST_VALID  output  1  Inst valid and awaiting STEP.
REQ-014 SHALL have port: PC  output  64  current program counter.
REQ-015 SHALL have port: FAULT  output  1  sticky fetch fault.
REQ-016 SHALL have parameter: TIMEOUT, default 16, max cycles MEM_RD may wait for MEM_ACK.

Function
REQ-017 SHALL implement states FETCH, HOLD, UPDATE, FAULT; nothing else.
REQ-018 FETCH: MEM_RD=1, MEM_ADDR=PC; on MEM_ACK, Inst<=MEM_RDATA, next state HOLD, MEM_RD=0 from next cycle.
REQ-019 HOLD: INST_VALID=1, MEM_RD=0; Inst and PC stable until STEP.
REQ-020 HOLD with STEP and PC_SEL=00: remain HOLD, no refetch, Inst unchanged (multicycle instruction support).
REQ-021 HOLD with STEP and PC_SEL!=00: compute new PC in that edge, INST_VALID=0 next cycle, next state UPDATE.
REQ-022 PC_SEL=01: PC<=PC+4.
REQ-023 PC_SEL=10, PC_MUX=1: PC<=PC+(sign-extend K[25:0] shifted left 2); PC_MUX=0: PC<=A.
REQ-024 PC_SEL=11: PC<=A regardless of PC_MUX.
REQ-025 All PC arithmetic modulo 2^64; wrap-around silent, not a fault.
REQ-026 UPDATE: one cycle; if PC[1:0]!=00 go FAULT, else go FETCH.
REQ-027 Latency: zero-wait memory (MEM_ACK in first FETCH cycle) gives INST_VALID=1 exactly 3 cycles after STEP edge.
REQ-028 STEP outside HOLD SHALL be ignored.
REQ-029 MEM_ACK outside FETCH SHALL be ignored; Inst unchanged.
REQ-030 Wait counter counts FETCH cycles without MEM_ACK; reaching TIMEOUT goes FAULT; MEM_ACK on the TIMEOUT-th cycle completes normally.
REQ-031 FAULT: FAULT=1, MEM_RD=0, INST_VALID=0, PC frozen; exit only by Reset.

Reset
REQ-032 Reset SHALL set PC=0, Inst=0, INST_VALID=0, MEM_RD=0, FAULT=0, wait counter=0, state FETCH; first fetch request in cycle after Reset deasserts.
REQ-033 Reset mid-FETCH SHALL abandon request; MEM_ACK in the Reset cycle discarded.
REQ-034 Reset has priority over STEP and MEM_ACK in the same cycle.

Verification
REQ-035 Reset, zero-wait memory returns 0x8B020020 at addr 0 -> MEM_ADDR=0, Inst=0x8B020020, INST_VALID=1 on 2nd cycle after Reset release.
REQ-036 HOLD, PC=0x100, STEP with PC_SEL=01 -> PC=0x104, MEM_ADDR=0x104, INST_VALID re-asserted 3 cycles later.
REQ-037 PC=0x100, STEP PC_SEL=10 PC_MUX=1 K[25:0]=0x3FFFFFE (-2) -> PC=0xF8; PC_SEL=11 A=0x2000 -> PC=0x2000.
REQ-038 STEP PC_SEL=00 three times -> no MEM_RD pulse, Inst and PC unchanged, INST_VALID held.
REQ-039 PC_SEL=11 A=0x2002 -> FAULT=1 after UPDATE, MEM_RD stays 0; MEM_ACK withheld 16 cycles -> FAULT=1; both clear only on Reset.
REQ-040 PC=0xFFFFFFFFFFFFFFFC, PC_SEL=01 -> PC=0, no fault; Reset asserted during a 5-cycle memory wait -> late MEM_ACK ignored, refetch from 0.
